// File: rtl/uart_event_framer.sv
// Frames UART RX bytes into DVS events buffered in an FWFT FIFO, and serialises
// gesture reports and control-command responses onto a byte-wide TX interface.
module uart_event_framer #(
  parameter int unsigned COORD_BITS   = 9,
  parameter int unsigned TS_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CHECKSUM_EN  = 0,
  parameter int unsigned BYTE_TIMEOUT = 1200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  event_valid,
  input  logic                  event_ready,
  output logic [COORD_BITS-1:0] event_x,
  output logic [COORD_BITS-1:0] event_y,
  output logic                  event_polarity,
  output logic [TS_WIDTH-1:0]   event_ts,
  input  logic                  gesture_valid,
  input  logic [1:0]            gesture,
  input  logic [3:0]            gesture_confidence,
  input  logic [7:0]            status_in,
  output logic                  soft_rst_req,
  output logic [15:0]           drop_count,
  output logic [7:0]            err_count
);
  localparam int unsigned CB      = (COORD_BITS + 7) / 8;
  localparam int unsigned XW      = CB * 8;
  localparam int unsigned PKT_LEN = 2 * CB + 1 + CHECKSUM_EN;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  IDX_Y    = 4'(CB);
  localparam logic [3:0]  IDX_POL  = 4'(2 * CB);
  localparam logic [3:0]  IDX_LAST = 4'(PKT_LEN - 1);
  localparam logic [31:0] TO_LAST  = (BYTE_TIMEOUT == 0) ? 32'd0 : 32'(BYTE_TIMEOUT - 1);

  typedef enum logic {StStart, StBody} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxLoad, TxIssue, TxWaitBusy} tx_state_e;

  rx_state_e             rx_st;
  logic [3:0]            idx;
  logic [31:0]           idle_cnt;
  logic [7:0]            chk;
  logic [XW-1:0]         x_acc, y_acc;
  logic                  pol_q;
  logic [TS_WIDTH-1:0]   ts_q;
  logic                  push_q, push_pol;
  logic [COORD_BITS-1:0] push_x, push_y;
  logic [TS_WIDTH-1:0]   push_ts;
  logic                  ctrl_pend, ctrl_take;

  // Control bytes only count in START, and are swallowed while one is pending.
  assign ctrl_take = rx_valid && (rx_st == StStart) && (rx_data >= 8'hFB) && !ctrl_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st        <= StStart;
      idx          <= '0;
      idle_cnt     <= '0;
      chk          <= '0;
      x_acc        <= '0;
      y_acc        <= '0;
      pol_q        <= 1'b0;
      ts_q         <= '0;
      push_q       <= 1'b0;
      push_pol     <= 1'b0;
      push_x       <= '0;
      push_y       <= '0;
      push_ts      <= '0;
      soft_rst_req <= 1'b0;
      err_count    <= '0;
    end else begin
      push_q       <= 1'b0;
      soft_rst_req <= ctrl_take && (rx_data == 8'hFC);
      ts_q         <= ts_q + TS_WIDTH'(1);
      if (rx_st == StStart) begin
        idle_cnt <= '0;
        if (rx_valid && rx_data < 8'hFB) begin
          rx_st <= StBody;
          idx   <= 4'd1;
          chk   <= rx_data;
          x_acc <= XW'(rx_data);
        end
      end else if (rx_valid) begin
        idle_cnt <= '0;
        idx      <= idx + 4'd1;
        chk      <= chk ^ rx_data;
        if (idx < IDX_Y) x_acc <= (x_acc << 8) | XW'(rx_data);
        else if (idx < IDX_POL) y_acc <= (y_acc << 8) | XW'(rx_data);
        if (idx == IDX_POL) pol_q <= rx_data[0];
        if (idx == IDX_LAST) begin
          rx_st <= StStart;
          if (CHECKSUM_EN == 0 || rx_data == chk) begin
            push_q   <= 1'b1;
            push_x   <= x_acc[COORD_BITS-1:0];
            push_y   <= y_acc[COORD_BITS-1:0];
            // Without a checksum the final byte is POL itself.
            push_pol <= (CHECKSUM_EN != 0) ? pol_q : rx_data[0];
            push_ts  <= ts_q;
          end else if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
      end else if (BYTE_TIMEOUT != 0) begin
        if (idle_cnt == TO_LAST) begin
          rx_st <= StStart;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          idle_cnt <= idle_cnt + 32'd1;
        end
      end
    end
  end

  logic [COORD_BITS-1:0] mem_x [FIFO_DEPTH];
  logic [COORD_BITS-1:0] mem_y [FIFO_DEPTH];
  logic                  mem_p [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_t [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           count;
  logic                  full, pop, do_push, drop;

  assign event_valid    = (count != '0);
  assign full           = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop            = event_valid && event_ready;
  assign do_push        = push_q && (!full || pop);
  assign drop           = push_q && full && !pop;
  assign event_x        = event_valid ? mem_x[rptr] : '0;
  assign event_y        = event_valid ? mem_y[rptr] : '0;
  assign event_polarity = event_valid ? mem_p[rptr] : 1'b0;
  assign event_ts       = event_valid ? mem_t[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (do_push) begin
        mem_x[wptr] <= push_x;
        mem_y[wptr] <= push_y;
        mem_p[wptr] <= push_pol;
        mem_t[wptr] <= push_ts;
        wptr        <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (do_push && !pop) count <= count + (AW + 1)'(1);
      else if (!do_push && pop) count <= count - (AW + 1)'(1);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  tx_state_e  tx_st;
  logic [1:0] byte_idx, g_q, sel_g;
  logic [3:0] c_q, sel_conf;
  logic       gesture_pend, sel_gest, last;
  logic [7:0] ctrl_code, sel_code, tx_byte;

  always_comb begin
    tx_byte = 8'h00;
    last    = 1'b1;
    if (sel_gest) begin
      tx_byte = (byte_idx == 2'd0) ? {4'hA, 2'b00, sel_g} : {sel_conf, 4'h0};
      last    = (byte_idx == 2'd1);
    end else begin
      case (sel_code)
        8'hFF: tx_byte = 8'h55;
        8'hFE: tx_byte = status_in;
        8'hFD: begin
          tx_byte = (byte_idx == 2'd0) ? 8'(COORD_BITS) : 8'(FIFO_DEPTH);
          last    = (byte_idx == 2'd1);
        end
        8'hFB: begin
          case (byte_idx)
            2'd0:    tx_byte = drop_count[15:8];
            2'd1:    tx_byte = drop_count[7:0];
            default: tx_byte = err_count;
          endcase
          last = (byte_idx == 2'd2);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st        <= TxIdle;
      byte_idx     <= '0;
      sel_gest     <= 1'b0;
      sel_g        <= '0;
      sel_conf     <= '0;
      sel_code     <= '0;
      gesture_pend <= 1'b0;
      g_q          <= '0;
      c_q          <= '0;
      ctrl_pend    <= 1'b0;
      ctrl_code    <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      case (tx_st)
        TxIdle: begin
          byte_idx <= '0;
          if (gesture_pend) begin
            sel_gest     <= 1'b1;
            sel_g        <= g_q;
            sel_conf     <= c_q;
            gesture_pend <= 1'b0;
            tx_st        <= TxLoad;
          end else if (ctrl_pend) begin
            sel_gest  <= 1'b0;
            sel_code  <= ctrl_code;
            ctrl_pend <= 1'b0;
            tx_st     <= TxLoad;
          end
        end
        TxLoad: tx_st <= TxIssue;
        TxIssue: begin
          if (!tx_busy) begin
            tx_data  <= tx_byte;
            tx_valid <= 1'b1;
            tx_st    <= last ? TxIdle : TxWaitBusy;
          end
        end
        default: begin
          if (tx_busy) begin
            byte_idx <= byte_idx + 2'd1;
            tx_st    <= TxIssue;
          end
        end
      endcase
      // New requests win over the clears above; a running sequence is never aborted.
      if (gesture_valid) begin
        gesture_pend <= 1'b1;
        g_q          <= gesture;
        c_q          <= gesture_confidence;
      end
      if (ctrl_take && rx_data != 8'hFC) begin
        ctrl_pend <= 1'b1;
        ctrl_code <= rx_data;
      end
    end
  end
endmodule

// File: doc/uart_event_framer.md
Name: uart_event_framer

Overview:
Parametrised successor to the fixed 5-byte UART event parser and responder in the UART gesture top. It frames RX bytes into DVS events of configurable coordinate width, with optional XOR checksum and inter-byte timeout resync. Framed events are buffered in an FWFT FIFO with a valid/ready output, so events are no longer lost when the accelerator stalls. It also serialises gesture reports and control responses onto a byte-wide UART TX interface. It sits between uart_rx/uart_tx and dvs_gesture_accel.

Parameters:
COORD_BITS, 9, width of event_x/event_y (1..16); COORD_BYTES = ceil(COORD_BITS/8).
TS_WIDTH, 16, free-running timestamp counter width.
FIFO_DEPTH, 8, event FIFO depth; power of 2, at least 2.
CHECKSUM_EN, 0, when 1 each packet carries a trailing XOR checksum byte.
BYTE_TIMEOUT, 1200, maximum idle cycles between bytes of one packet; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte
rx_valid  in  1  single-cycle strobe for rx_data
tx_busy  in  1  UART transmitter busy
tx_data  out  8  byte to transmit
tx_valid  out  1  single-cycle transmit strobe
event_valid  out  1  FIFO non-empty
event_ready  in  1  consumer accepts the head event
event_x  out  COORD_BITS  head event x
event_y  out  COORD_BITS  head event y
event_polarity  out  1  head event polarity
event_ts  out  TS_WIDTH  head event timestamp
gesture_valid  in  1  gesture detection strobe
gesture  in  2  gesture code
gesture_confidence  in  4  gesture confidence
status_in  in  8  byte returned for the status command
soft_rst_req  out  1  single-cycle soft-reset request
drop_count  out  16  saturating count of FIFO-full drops
err_count  out  8  saturating count of checksum and timeout errors

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; FIFO empty; parser at START; TX FSM IDLE; ts counter 0; pending flags cleared.
- Packet layout: X bytes MSB-first, then Y bytes MSB-first, then POL (bit 0 used), then CHK if CHECKSUM_EN.
  - Each coordinate is COORD_BYTES bytes. Unused upper bits of the high byte are ignored.
  - Packet length = 2*COORD_BYTES + 1 + CHECKSUM_EN.
- Control bytes are recognised only in START state:
  - 0xFF: echo, responds 0x55.
  - 0xFE: status, responds status_in sampled at TX issue.
  - 0xFD: config, responds COORD_BITS, then FIFO_DEPTH[7:0].
  - 0xFC: pulses soft_rst_req on the cycle after the byte. The parser itself is not cleared; the top ORs soft_rst_req into rst.
  - 0xFB: counter readback, responds drop_count[15:8], drop_count[7:0], err_count.
  - Any other byte in START is the first X byte.
- Packet completion:
  - ts is captured on the final-byte cycle; ts counter wraps modulo 2^TS_WIDTH.
  - CHK must equal the XOR of all preceding packet bytes. On mismatch: discard the packet, err_count++.
  - A valid packet is pushed into the FIFO the cycle after its final byte. If the FIFO is full: drop, drop_count++. Both counters saturate, never wrap.
- Timeout: mid-packet with no rx_valid for BYTE_TIMEOUT consecutive cycles → parser returns to START, err_count++.
- FIFO is first-word fall-through:
  - event_valid = !empty; pop on event_valid && event_ready.
  - Simultaneous push and pop while full: the pop frees a slot, so the push succeeds and nothing is dropped.
  - Push into empty: event_valid rises one cycle after the push cycle.
- TX pending flags:
  - gesture_valid sets gesture_pend and overwrites the latched gesture/confidence (latest wins).
  - A control command sets ctrl_pend and ctrl_code. While ctrl_pend=1, further control bytes are ignored (no response, no error).
- TX FSM states: IDLE, LOAD, ISSUE, WAIT_BUSY.
  - IDLE: if gesture_pend, select gesture (priority); else if ctrl_pend, select ctrl. Clear the selected flag and go to LOAD with byte_idx=0.
  - ISSUE: when !tx_busy, drive tx_data and tx_valid=1 for one cycle. If this was the last byte of the sequence go to IDLE, else go to WAIT_BUSY.
  - WAIT_BUSY: on tx_busy=1, byte_idx++ and go to ISSUE.
  - Gesture response = two bytes: {4'hA, 2'b00, gesture}, then {confidence, 4'h0}.
- A new gesture_valid arriving during a sequence does not abort it; it is sent afterwards.

Test Plan:
- COORD_BITS=9, no checksum: bytes 01 2C 00 F0 01, event_ready=1 → one event x=300, y=240, pol=1; event_valid high for 1 cycle; drop_count=0.
- FIFO_DEPTH=8, event_ready=0, send 10 valid packets → event_valid=1, FIFO holds the first 8 in order, drop_count=2. Then event_ready=1 → exactly 8 pops, in arrival order.
- CHECKSUM_EN=1: packet 00 05 00 06 01 02 (correct) → pushed. Packet 00 05 00 06 01 03 → discarded, err_count=1.
- Send 00 05, then idle BYTE_TIMEOUT cycles, then byte FF → err_count=1, parser resynced, 0x55 emitted.
- gesture_valid with gesture=2, conf=9 on the same cycle as rx 0xFF, tx_busy model 10 cycles/byte → TX sequence A2, 90, 55.
- Byte 0xFB after 3 drops and 1 error → TX 00, 03, 01. Byte 0xFC → soft_rst_req high exactly one cycle.
